// File: rtl/mem_stage_pkg.sv
// Purpose : shared encodings for the MEM-stage load/store unit.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_pkg;

    // mem_size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Largest WAIT_STATES that fits the 4-bit wait counter
    localparam int MAX_WAIT_STATES = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Purpose : byte-lane steering for sub-word loads/stores plus alignment check.
// Latency : purely combinational, zero cycles.
// Backpressure: none; the caller decides when results are used.
// Ports   : size/addr_lo/is_unsigned describe the access; st_data is store data,
//           ram_word the word being merged into, ld_word the word loaded from.
//           Outputs: be (byte enables), wr_word (merged word), ld_ext
//           (extended load value), align_err (illegal size/alignment).
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] ram_word,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wr_word,
    output logic [31:0] ld_ext,
    output logic        align_err
);

    logic [31:0] w_rep;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        be        = 4'b0000;
        w_rep     = st_data;
        w_byte    = ld_word[{addr_lo, 3'b000} +: 8];
        w_half    = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        ld_ext    = ld_word;
        align_err = 1'b0;
        wr_word   = ram_word;

        case (size)
            SZ_BYTE: begin
                be     = 4'b0001 << addr_lo;
                w_rep  = {4{st_data[7:0]}};
                ld_ext = is_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                align_err = addr_lo[0];
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                w_rep     = {2{st_data[15:0]}};
                ld_ext    = is_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                align_err = (addr_lo != 2'b00);
                be        = 4'b1111;
            end
            default: begin
                align_err = 1'b1;
            end
        endcase

        // Data is replicated across lanes so every enabled lane sees the right byte;
        // disabled lanes keep the current RAM contents.
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                wr_word[8*i +: 8] = w_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Purpose : MEM stage with local data RAM, sub-word loads/stores, wait states.
// Latency : request in cycle 0 commits at end of cycle WAIT_STATES+1, done in WAIT_STATES+2.
// Backpressure: mem_stall holds the pipeline from the request cycle until the commit edge.
// Ports   : clk/rst_n (sync, active-low); mem_rd/mem_wr/mem_size/mem_unsigned,
//           ALU_Result (byte address), WriteData in; ReadData (registered),
//           mem_stall, mem_done (1-cycle pulse), misaligned (combinational) out.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] ALU_Result,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          r_rd, r_wr, r_uns;
    logic [1:0]    r_size;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_idle, w_one_op, w_legal, w_commit;
    logic [1:0]    w_size_sel, w_alo_sel;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_ram_word, w_wr_word, w_ld_ext;
    logic [3:0]    w_be;
    logic          w_align_err;
    logic          w_unused_addr_hi;

    // Address bits above the RAM wrap are deliberately dropped.
    assign w_unused_addr_hi = ^ALU_Result[31:AW+2];

    assign w_idle   = (r_state == IDLE);
    assign w_one_op = mem_rd ^ mem_wr;

    // In IDLE the aligner checks the live request; afterwards it works on the latched copy.
    assign w_size_sel = w_idle ? mem_size         : r_size;
    assign w_alo_sel  = w_idle ? ALU_Result[1:0]  : r_addr[1:0];

    assign w_idx      = r_addr[AW+1:2];
    assign w_ram_word = r_mem[w_idx];

    lsu_align u_align (
        .size        (w_size_sel),
        .addr_lo     (w_alo_sel),
        .is_unsigned (r_uns),
        .st_data     (r_wdata),
        .ram_word    (w_ram_word),
        .ld_word     (w_ram_word),
        .be          (w_be),
        .wr_word     (w_wr_word),
        .ld_ext      (w_ld_ext),
        .align_err   (w_align_err)
    );

    assign w_legal    = w_idle && w_one_op && !w_align_err;
    assign misaligned = w_idle && (mem_rd || mem_wr) && (!w_one_op || w_align_err);
    assign w_commit   = (r_state == WAIT) && (r_cnt == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        mem_stall   = 1'b0;
        mem_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_legal) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = 4'(WAIT_STATES);
                    mem_stall   = 1'b1;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                mem_done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            ReadData <= 32'd0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_uns    <= 1'b0;
            r_size   <= SZ_BYTE;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_legal) begin
                r_rd    <= mem_rd;
                r_wr    <= mem_wr;
                r_uns   <= mem_unsigned;
                r_size  <= mem_size;
                r_addr  <= ALU_Result[AW+1:0];
                r_wdata <= WriteData;
            end
            if (w_commit && r_rd) begin
                ReadData <= w_ld_ext;
            end
        end
    end

    // RAM is not reset; a reset on the commit edge suppresses the store.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && r_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wr_word[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised successor to the single-cycle MEM stage for the pipelined core. It adds sub-word loads and stores (byte, half, word) with sign or zero extension, byte-lane store merging and alignment checking. Memory latency is configurable, and a stall handshake holds the pipeline while the access is in flight. The local data RAM sits inside the block, between EX/MEM and MEM/WB.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the RAM; power of 2.
WAIT_STATES, 2, extra cycles before the access commits; range 0..15.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  reset, synchronous, active-low.
mem_rd  in  1  load request.
mem_wr  in  1  store request.
mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
mem_unsigned  in  1  loads only: 1 zero-extends, 0 sign-extends.
ALU_Result  in  32  byte address.
WriteData  in  32  store data; LSBs used for byte and half stores.
ReadData  out  32  extended load result, registered.
mem_stall  out  1  pipeline must hold the MEM stage.
mem_done  out  1  one-cycle pulse when an access completes.
misaligned  out  1  illegal request flag, combinational.

Behaviour:
- Reset:
  - Sampled only at a clock edge while rst_n=0.
  - Sets state IDLE, counter 0, ReadData 0, mem_done 0, latched request cleared.
  - RAM contents are not reset.
- Legal request: exactly one of mem_rd/mem_wr is high, and alignment holds:
  - byte: any address;
  - half: ALU_Result[0]=0;
  - word: ALU_Result[1:0]=0;
  - mem_size=11 is always illegal.
- Illegal request in IDLE:
  - misaligned=1 in that same cycle, mem_stall=0.
  - No state change, no RAM write, ReadData unchanged.
- Addressing:
  - Word index = ALU_Result[log2(DEPTH_WORDS)+1:2].
  - Higher bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Byte order is little-endian.
- FSM states:
  - IDLE: a legal request latches op, size, unsigned flag, address and data; counter loads WAIT_STATES; next state is WAIT. mem_stall=1 combinationally in this cycle.
  - WAIT: mem_stall=1. If counter≠0, decrement and stay. If counter=0, perform the access at this edge and go to RESP.
  - RESP: mem_stall=0, mem_done=1. ReadData holds the new load value. The request still on the inputs is ignored. Next state is IDLE.
- Timing, request first seen in cycle 0:
  - mem_stall is high in cycles 0..WAIT_STATES+1.
  - mem_done is high in cycle WAIT_STATES+2.
  - The access commits at the edge that ends cycle WAIT_STATES+1.
  - With WAIT_STATES=0: stall in cycles 0 and 1, done in cycle 2.
- Input changes while in WAIT or RESP are ignored; only the latched copy is used.
- Store merge:
  - SB writes byte lane addr[1:0] with WriteData[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with WriteData[15:0].
  - SW writes all four lanes.
  - Other lanes are preserved.
- Load extract:
  - Select the byte or half by address.
  - Extend to 32 bits per the latched unsigned flag.
  - ReadData is written only on load completion; stores leave it unchanged.
- Reset during WAIT: the access is aborted and a pending store is not committed. Reset during RESP: mem_done drops at the reset edge.

Decomposition:
- Package mem_stage_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the FSM state enum IDLE/WAIT/RESP;
  - the maximum WAIT_STATES constant.
- One combinational sub-module, lsu_align. Its inputs are size, address[1:0], unsigned flag, store data, RAM word and load word. Its outputs are:
  - the 4-bit byte enable;
  - the merged write word;
  - the extended load value;
  - the alignment-error flag.
- The FSM, counter and RAM array stay in the top module.

Test Plan:
1. Reset, WAIT_STATES=2. SW 0xDEADBEEF @0x10 → mem_stall high cycles 0-3, mem_done in cycle 4. Then LW @0x10 → ReadData=0xDEADBEEF.
2. SB 0x0000007F @0x11, then LW @0x10 → 0xDEAD7FEF. LB @0x13 → 0xFFFFFFDE. LBU @0x13 → 0x000000DE.
3. SH 0x00008001 @0x12, then LH @0x12 → 0xFFFF8001, LHU → 0x00008001, LW @0x10 → 0x80017FEF.
4. Illegal requests → misaligned=1 same cycle, mem_stall=0, no mem_done, LW @0x10 still 0x80017FEF. Cases:
   - LW @0x12;
   - SH @0x13;
   - mem_size=11;
   - mem_rd and mem_wr both high.
5. SW 0x12345678 @0x20 with rst_n pulsed low in the second WAIT cycle → next cycle IDLE, mem_stall=0, ReadData=0. Subsequent LW @0x20 returns the prior contents, not 0x12345678.
6. WAIT_STATES=0, DEPTH_WORDS=256. SW 0xCAFEF00D @0x400, then LW @0x000 → 0xCAFEF00D (wrap). Stall cycles 0-1, done in cycle 2 for each access.
